// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx scheduler.
package uart_pkg;

  // Scheduler phases: arbitrate, pulse write, wait for the frame to start,
  // wait for it to end, then acknowledge.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    WRH  = 3'd2,
    WRL  = 3'd3,
    BUSY = 3'd4,
    DONE = 3'd5
  } sched_st_t;

  // Cycles to wait for tx_idle to fall after write falls.
  localparam int DEF_TMO = 64;

  // Bits needed to hold 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Index wrap for round-robin arithmetic; a is always below 2*n.
  function automatic int rr_wrap(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Round-robin picker: first set request scanning from i_ptr upward, mod N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  // Slot visited at scan step k, starting from the pointer.
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] ptr, input int k);
    return PTR_W'(rr_wrap(int'(ptr) + k, N));
  endfunction

  // Scan farthest-first so the slot nearest the pointer is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[slot(i_ptr, k)]) begin
        o_onehot                 = '0;
        o_onehot[slot(i_ptr, k)] = 1'b1;
        o_idx                    = slot(i_ptr, k);
        o_valid                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N byte producers.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int WR_HI = 1,
  parameter int TMO   = DEF_TMO
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            setb,
  input  logic [N-1:0]    req,
  input  logic [N*8-1:0]  req_data,
  input  logic [N*16-1:0] req_div,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    err,
  output logic [N-1:0]    grant,
  output logic            tx_write,
  output logic [7:0]      tx_data,
  output logic [15:0]     tx_div,
  input  logic            tx_idle,
  output logic            busy
);

  localparam int PTR_W  = $clog2(N);
  localparam int CNT_W  = cnt_width(TMO);
  localparam int HCNT_W = cnt_width(WR_HI);

  sched_st_t          r_state;
  sched_st_t          w_state_nx;
  logic               w_tmo_hit;

  logic [N-1:0]       r_grant;
  logic [N-1:0]       r_ack;
  logic [N-1:0]       r_err;
  logic               r_tx_write;
  logic [7:0]         r_tx_data;
  logic [15:0]        r_tx_div;
  logic               r_busy;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_widx;
  logic [CNT_W-1:0]   r_cnt;
  logic [HCNT_W-1:0]  r_hcnt;
  logic               r_tmo;

  logic [N-1:0]       w_pick_onehot;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_valid;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .i_req    (req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // State register; setb=0 holds the FSM where it is.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst)       r_state <= IDLE;
    else if (setb) r_state <= w_state_nx;
  end

  // Next-state decode and the timeout decision taken in WRL.
  always_comb begin
    w_state_nx = r_state;
    w_tmo_hit  = 1'b0;
    case (r_state)
      IDLE: if (|req && tx_idle) w_state_nx = ARB;
      ARB:  w_state_nx = w_pick_valid ? WRH : IDLE;
      WRH:  if (r_hcnt == HCNT_W'(WR_HI - 1)) w_state_nx = WRL;
      // The frame has started only once idle is seen low; a late fall is tolerated.
      WRL: begin
        if (!tx_idle) begin
          w_state_nx = BUSY;
        end else if (TMO != 0 && r_cnt == CNT_W'(TMO - 1)) begin
          w_state_nx = DONE;
          w_tmo_hit  = 1'b1;
        end
      end
      // Frame length depends on the divider, so no timeout here.
      BUSY:    if (tx_idle) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; all frozen while setb=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_tx_write <= 1'b0;
      r_tx_data  <= '0;
      r_tx_div   <= '0;
      r_busy     <= 1'b0;
      r_rr_ptr   <= '0;
      r_widx     <= '0;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_tmo      <= 1'b0;
    end else if (setb) begin
      r_ack      <= '0;
      r_err      <= '0;
      r_tx_write <= (w_state_nx == WRH);
      r_busy     <= (w_state_nx != IDLE);
      case (r_state)
        // tx_data/tx_div are captured here only and held until the next ARB,
        // since uart_tx reads data at load and the divider on every bit.
        ARB: begin
          if (w_pick_valid) begin
            r_grant   <= w_pick_onehot;
            r_widx    <= w_pick_idx;
            r_tx_data <= req_data[int'(w_pick_idx)*8 +: 8];
            r_tx_div  <= req_div[int'(w_pick_idx)*16 +: 16];
            r_tmo     <= 1'b0;
            r_hcnt    <= '0;
            r_cnt     <= '0;
          end else begin
            r_grant <= '0;
          end
        end
        WRH: r_hcnt <= r_hcnt + 1'b1;
        WRL: begin
          if (w_tmo_hit)       r_tmo <= 1'b1;
          else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        // Release the UART and move priority just past the served producer.
        DONE: begin
          r_ack    <= r_grant;
          r_err    <= r_tmo ? r_grant : '0;
          r_grant  <= '0;
          r_rr_ptr <= PTR_W'(rr_wrap(int'(r_widx) + 1, N));
        end
        default: ;
      endcase
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign grant    = r_grant;
  assign tx_write = r_tx_write;
  assign tx_data  = r_tx_data;
  assign tx_div   = r_tx_div;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx, line decoder, round-robin model.
module tb_uart_tx_sched;

  localparam int N     = 4;
  localparam int WR_HI = 1;
  localparam int TMO   = 8;

  logic            clk;
  logic            rst;
  logic            setb;
  logic [N-1:0]    req;
  logic [N*8-1:0]  req_data;
  logic [N*16-1:0] req_div;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [N-1:0]    grant;
  logic            tx_write;
  logic [7:0]      tx_data;
  logic [15:0]     tx_div;
  logic            tx_idle;
  logic            busy;

  logic force_idle;   // 1: UART disconnected, idle reads 1
  logic m_idle;
  logic m_line;

  int n_cmp = 0;
  int n_bad = 0;
  int rr_next = 0;    // model: slot with top priority

  typedef struct {
    logic [7:0] data;
    bit         ok;
  } rx_t;
  rx_t rx_q[$];

  uart_tx_sched #(.N(N), .WR_HI(WR_HI), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .setb     (setb),
    .req      (req),
    .req_data (req_data),
    .req_div  (req_div),
    .ack      (ack),
    .err      (err),
    .grant    (grant),
    .tx_write (tx_write),
    .tx_data  (tx_data),
    .tx_div   (tx_div),
    .tx_idle  (tx_idle),
    .busy     (busy)
  );

  assign tx_idle = force_idle | m_idle;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural uart_tx: loads on write rise, idle falls 2 cycles later,
  // sends start, 8 data LSB first, even parity, stop; div cycles per bit.
  logic        u_busy;
  logic        u_prev_wr;
  int          u_dly;
  int          u_tick;
  int          u_left;
  logic [10:0] u_sh;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_busy <= 1'b0; u_prev_wr <= 1'b0; u_dly <= 0; u_tick <= 0; u_left <= 0;
      u_sh <= '1; m_idle <= 1'b1; m_line <= 1'b1;
    end else begin
      u_prev_wr <= tx_write;
      if (!u_busy) begin
        if (tx_write && !u_prev_wr && !force_idle) begin
          u_busy <= 1'b1;
          u_dly  <= 2;
          u_sh   <= {1'b1, ^tx_data, tx_data, 1'b0};
        end
      end else if (u_dly > 0) begin
        u_dly <= u_dly - 1;
        if (u_dly == 1) begin
          m_idle <= 1'b0; m_line <= u_sh[0]; u_tick <= 0; u_left <= 10;
        end
      end else if (u_tick + 1 >= int'(tx_div)) begin
        u_tick <= 0;
        if (u_left == 0) begin
          u_busy <= 1'b0; m_idle <= 1'b1; m_line <= 1'b1;
        end else begin
          u_left <= u_left - 1; u_sh <= u_sh >> 1; m_line <= u_sh[1];
        end
      end else begin
        u_tick <= u_tick + 1;
      end
    end
  end

  // Line decoder: mid-bit sampling using the held divider.
  logic        d_act;
  logic        d_prev;
  int          d_cnt;
  int          d_n;
  logic [10:0] d_bits;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_act <= 1'b0; d_prev <= 1'b1; d_cnt <= 0; d_n <= 0; d_bits <= '0;
    end else begin
      d_prev <= m_line;
      if (!d_act) begin
        if (d_prev && !m_line) begin
          d_act <= 1'b1; d_cnt <= 1; d_n <= 0;
        end
      end else begin
        d_cnt <= d_cnt + 1;
        if (d_cnt % int'(tx_div) == int'(tx_div) / 2) begin
          if (d_n == 10) begin
            rx_q.push_back('{data: d_bits[9:2],
                             ok: (d_bits[1] == 1'b0) && m_line && (d_bits[10] == ^d_bits[9:2])});
            d_act <= 1'b0;
          end else begin
            d_bits <= {m_line, d_bits[10:1]};
            d_n    <= d_n + 1;
          end
        end
      end
    end
  end

  // Reference arbitration: first requester at or after start, mod N.
  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output logic [N-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (grant != '0) begin
        g  = grant;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget, input logic [N-1:0] g, output bit ok, output bit stable);
    ok     = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
      if (grant !== g) stable = 1'b0;
    end
  endtask

  task automatic randomize_slots();
    for (int i = 0; i < N; i++) begin
      req_data[i*8 +: 8]   = 8'($urandom);
      req_div[i*16 +: 16]  = 16'($urandom_range(2, 5));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; setb = 1'b1; force_idle = 1'b0;
    req = '0; req_data = '0; req_div = '0;
    repeat (3) tick();
    n_cmp++;
    if ({ack, err, grant} !== '0) begin
      n_bad++; $display("FAIL reset_handshake: got %b expected 0", {ack, err, grant});
    end
    n_cmp++;
    if (tx_write !== 1'b0) begin
      n_bad++; $display("FAIL reset_write: got %b expected 0", tx_write);
    end
    n_cmp++;
    if ({tx_data, tx_div} !== '0) begin
      n_bad++; $display("FAIL reset_data_div: got %h expected 0", {tx_data, tx_div});
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_bad++; $display("FAIL idle_no_req: busy %b grant %b expected 0", busy, grant);
    end
    rr_next = 0;
  endtask

  task automatic test_single();
    int lat, hi, w;
    bit got, ok, stable;
    logic [N-1:0] ge;
    rx_t rx;
    req_data[7:0] = 8'hA5; req_div[15:0] = 16'd3;
    req = 4'b0001;
    w = pick(req, rr_next); ge = '0; ge[w] = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); lat++;
      if (tx_write) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got || lat != 2) begin
      n_bad++; $display("FAIL write_latency: got %0d cycles (seen %b) expected 2", lat, got);
    end
    n_cmp++;
    if (grant !== ge || tx_data !== 8'hA5 || tx_div !== 16'd3) begin
      n_bad++; $display("FAIL single_grant: grant %b data %h div %0d expected %b A5 3", grant, tx_data, tx_div, ge);
    end
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!tx_write) break;
      hi++;
    end
    n_cmp++;
    if (hi != WR_HI) begin
      n_bad++; $display("FAIL write_width: got %0d expected %0d", hi, WR_HI);
    end
    wait_ack(800, ge, ok, stable);
    req = '0;
    n_cmp++;
    if (!ok || ack !== ge || err !== '0) begin
      n_bad++; $display("FAIL single_ack: ok %b ack %b err %b expected %b 0", ok, ack, err, ge);
    end
    tick();
    n_cmp++;
    if (ack !== '0) begin
      n_bad++; $display("FAIL ack_one_cycle: got %b expected 0", ack);
    end
    n_cmp++;
    if (rx_q.size() != 1) begin
      n_bad++; $display("FAIL single_frames: got %0d expected 1", rx_q.size());
    end else begin
      rx = rx_q.pop_front();
      if (rx.data !== 8'hA5 || !rx.ok) begin
        n_bad++; $display("FAIL single_line: got %h ok %b expected A5 ok 1", rx.data, rx.ok);
      end
    end
    rr_next = (w + 1) % N;
  endtask

  task automatic test_round_robin(input int iters);
    logic [N-1:0] r, g, ge;
    logic [7:0]   exp_d;
    logic [15:0]  exp_v;
    int w;
    bit ok, stable;
    rx_t rx;
    rst = 1'b1; tick(); tick(); rst = 1'b0; rr_next = 0; rx_q.delete();
    tick();
    for (int it = 0; it < iters; it++) begin
      r = (it < 5) ? '1 : N'($urandom_range(1, (1 << N) - 1));
      req = r;
      randomize_slots();
      w = pick(r, rr_next); ge = '0; ge[w] = 1'b1;
      exp_d = req_data[w*8 +: 8]; exp_v = req_div[w*16 +: 16];
      wait_grant(20, g, ok);
      n_cmp++;
      if (!ok || g !== ge) begin
        n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", it, g, ge);
      end
      if (it >= 5 && $urandom_range(0, 1) == 1) req[w] = 1'b0;
      randomize_slots();
      tick();
      n_cmp++;
      if (tx_data !== exp_d || tx_div !== exp_v || busy !== 1'b1) begin
        n_bad++; $display("FAIL rr_hold[%0d]: data %h div %0d busy %b expected %h %0d 1", it, tx_data, tx_div, busy, exp_d, exp_v);
      end
      wait_ack(1000, ge, ok, stable);
      n_cmp++;
      if (!ok || !stable || ack !== ge || err !== '0) begin
        n_bad++; $display("FAIL rr_ack[%0d]: ok %b stable %b ack %b err %b expected %b", it, ok, stable, ack, err, ge);
      end
      n_cmp++;
      if (rx_q.size() == 0) begin
        n_bad++; $display("FAIL rr_line[%0d]: got no frame expected %h", it, exp_d);
      end else begin
        rx = rx_q.pop_front();
        if (rx.data !== exp_d || !rx.ok) begin
          n_bad++; $display("FAIL rr_line[%0d]: got %h ok %b expected %h", it, rx.data, rx.ok, exp_d);
        end
      end
      rr_next = (w + 1) % N;
    end
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    logic [N-1:0] g, ge;
    logic [7:0]   exp_d;
    int w;
    bit ok, stable;
    rx_t rx;
    randomize_slots();
    req_data[2*8 +: 8] = 8'h3C; req_div[2*16 +: 16] = 16'd3;
    req = 4'b0100;
    w = pick(req, rr_next); ge = '0; ge[w] = 1'b1;
    wait_grant(20, g, ok);
    req = 4'b0010;
    n_cmp++;
    if (!ok || g !== ge) begin
      n_bad++; $display("FAIL drop_grant: got %b expected %b", g, ge);
    end
    wait_ack(800, ge, ok, stable);
    n_cmp++;
    if (!ok || !stable || ack !== ge || err !== '0) begin
      n_bad++; $display("FAIL drop_ack: ok %b stable %b ack %b err %b expected %b", ok, stable, ack, err, ge);
    end
    n_cmp++;
    if (rx_q.size() == 0) begin
      n_bad++; $display("FAIL drop_line: got no frame expected 3c");
    end else begin
      rx = rx_q.pop_front();
      if (rx.data !== 8'h3C || !rx.ok) begin
        n_bad++; $display("FAIL drop_line: got %h ok %b expected 3c", rx.data, rx.ok);
      end
    end
    rr_next = (w + 1) % N;
    w = pick(req, rr_next); ge = '0; ge[w] = 1'b1;
    exp_d = req_data[w*8 +: 8];
    wait_grant(20, g, ok);
    n_cmp++;
    if (!ok || g !== ge) begin
      n_bad++; $display("FAIL drop_next_grant: got %b expected %b", g, ge);
    end
    wait_ack(800, ge, ok, stable);
    req = '0;
    n_cmp++;
    if (!ok || ack !== ge || rx_q.size() == 0 || rx_q[0].data !== exp_d) begin
      n_bad++; $display("FAIL drop_next_ack: ok %b ack %b expected %b data %h", ok, ack, ge, exp_d);
    end
    rx_q.delete();
    rr_next = (w + 1) % N;
    tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] ge;
    int w, k, exp_k;
    bit seen, fell, got;
    force_idle = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req = (p == 0) ? 4'b1000 : 4'b0001;
      w = pick(req, rr_next); ge = '0; ge[w] = 1'b1;
      seen = 1'b0; fell = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (tx_write) begin seen = 1'b1; break; end
      end
      for (int i = 0; i < 10 && seen; i++) begin
        tick();
        if (!tx_write) begin fell = 1'b1; break; end
      end
      n_cmp++;
      if (!seen || !fell) begin
        n_bad++; $display("FAIL tmo_write[%0d]: rose %b fell %b expected 1 1", p, seen, fell);
      end
      k = 0; got = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (p == 1 && k == 3) setb = 1'b0;
        if (p == 1 && k == 8) setb = 1'b1;
        tick(); k++;
        if (ack != '0) begin got = 1'b1; break; end
      end
      req = '0; setb = 1'b1;
      exp_k = (p == 1) ? 14 : 9;
      n_cmp++;
      if (!got || k != exp_k) begin
        n_bad++; $display("FAIL tmo_delay[%0d]: got %0d cycles (seen %b) expected %0d", p, k, got, exp_k);
      end
      n_cmp++;
      if (ack !== ge || err !== ge || grant !== '0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL tmo_flags[%0d]: ack %b err %b grant %b busy %b expected %b %b 0 0", p, ack, err, grant, busy, ge, ge);
      end
      rr_next = (w + 1) % N;
      tick();
    end
    n_cmp++;
    if (rx_q.size() != 0) begin
      n_bad++; $display("FAIL tmo_line: got %0d frames expected 0", rx_q.size());
    end
    force_idle = 1'b0;
    tick();
  endtask

  task automatic test_setb();
    logic [N-1:0] ge;
    logic [7:0]   exp_d;
    int w;
    bit seen, held, frozen, ok, stable;
    randomize_slots();
    req_div[0 +: 16] = 16'd4;
    req = 4'b0001;
    w = pick(req, rr_next); ge = '0; ge[w] = 1'b1;
    exp_d = req_data[w*8 +: 8];
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_write) begin seen = 1'b1; break; end
    end
    setb = 1'b0; held = seen;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tx_write !== 1'b1) held = 1'b0;
    end
    setb = 1'b1;
    n_cmp++;
    if (!held) begin
      n_bad++; $display("FAIL setb_wrh_hold: got write %b expected held 1", tx_write);
    end
    tick();
    n_cmp++;
    if (tx_write !== 1'b0) begin
      n_bad++; $display("FAIL setb_resume_wrl: got %b expected 0", tx_write);
    end
    setb = 1'b0; frozen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_write !== 1'b0 || grant !== ge || busy !== 1'b1 || ack !== '0 || err !== '0) frozen = 1'b0;
    end
    setb = 1'b1;
    n_cmp++;
    if (!frozen) begin
      n_bad++; $display("FAIL setb_freeze: grant %b busy %b ack %b expected %b 1 0", grant, busy, ack, ge);
    end
    wait_ack(800, ge, ok, stable);
    req = '0;
    n_cmp++;
    if (!ok || ack !== ge || err !== '0) begin
      n_bad++; $display("FAIL setb_ack: ok %b ack %b err %b expected %b 0", ok, ack, err, ge);
    end
    n_cmp++;
    if (rx_q.size() == 0 || rx_q[0].data !== exp_d || !rx_q[0].ok) begin
      n_bad++; $display("FAIL setb_line: frames %0d expected %h", rx_q.size(), exp_d);
    end
    rx_q.delete();
    rr_next = (w + 1) % N;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g, ge;
    logic [7:0]   exp_d;
    int w, n_ack;
    bit ok, stable, low;
    randomize_slots();
    req_div[2*16 +: 16] = 16'd4;
    req = 4'b0100;
    wait_grant(20, g, ok);
    low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!m_idle) begin low = 1'b1; break; end
    end
    repeat (5) tick();
    rst = 1'b1; req = '0;
    #1;
    n_cmp++;
    if (!ok || !low || grant !== '0 || tx_write !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
      n_bad++; $display("FAIL rst_mid: started %b/%b grant %b write %b busy %b ack %b expected 0", ok, low, grant, tx_write, busy, ack);
    end
    tick(); tick();
    rst = 1'b0; rx_q.delete(); rr_next = 0;
    n_ack = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack != '0) n_ack++;
    end
    n_cmp++;
    if (n_ack != 0) begin
      n_bad++; $display("FAIL rst_no_ack: got %0d acks expected 0", n_ack);
    end
    randomize_slots();
    req = 4'b0010;
    w = pick(req, rr_next); ge = '0; ge[w] = 1'b1;
    exp_d = req_data[w*8 +: 8];
    wait_grant(20, g, ok);
    n_cmp++;
    if (!ok || g !== ge) begin
      n_bad++; $display("FAIL rst_after_grant: got %b expected %b", g, ge);
    end
    wait_ack(800, ge, ok, stable);
    req = '0;
    n_cmp++;
    if (!ok || ack !== ge || rx_q.size() == 0 || rx_q[0].data !== exp_d || !rx_q[0].ok) begin
      n_bad++; $display("FAIL rst_after_frame: ok %b ack %b frames %0d expected %b %h", ok, ack, rx_q.size(), ge, exp_d);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin(16);
    test_drop();
    test_timeout();
    test_setb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
